fifo_wr_ctrl: RTL

Pointer and occupancy controller for an 8-entry register-based FIFO. It sits directly upstream of the 3-to-8 write-enable decoder. It turns push/pop requests into a binary write index plus write strobe, which feed the decoder's `in`/`en`, and a binary read index for the read mux. It tracks full, empty, count, almost-full and sticky error flags. It holds no data storage.

---
 rtl/fifo_wr_ctrl.sv | 58 +++++
 1 files changed

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: pointer/occupancy controller for a register FIFO, drives a 3-to-8 write decoder
module fifo_wr_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    output logic [ADDR_W-1:0] wr_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] rd_idx,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AF_THRESH);
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    // occupancy and acceptance derived from the wrap-bit pointers; a push into a full
    // FIFO is allowed alongside a pop because the freed slot is read before the edge
    always_comb begin
        count       = wr_ptr - rd_ptr;
        empty       = wr_ptr == rd_ptr;
        full        = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
        almost_full = count >= AF;
        pop_ok      = pop && !empty && !flush;
        push_ok     = push && (!full || pop) && !flush;
        wr_en       = push_ok && rst_n;
        rd_valid    = pop_ok && rst_n;
        wr_idx      = wr_ptr[ADDR_W-1:0];
        rd_idx      = rd_ptr[ADDR_W-1:0];
    end
    // pointer advance and sticky error flags; flush clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + {{ADDR_W{1'b0}}, push_ok};
            rd_ptr    <= rd_ptr + {{ADDR_W{1'b0}}, pop_ok};
            overflow  <= overflow || (push && full && !pop);
            underflow <= underflow || (pop && empty);
        end
    end
endmodule
